fetch_buffer: RTL

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer_pkg.sv | 38 +++
 rtl/fetch_buffer_ram.sv | 27 ++
 rtl/fetch_buffer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fetch_buffer_pkg.sv
// Shared constants and the packed entry layout for the fetch buffer.
// Empty-output defaults live here so every consumer agrees on them.
package fetch_buffer_pkg;

  localparam logic [31:0] INST_NOP     = 32'h0340_0000;
  localparam logic [31:0] PC_RESET     = 32'h1c00_0000;
  localparam logic [31:0] EMPTY_COOKIE = 32'd1958;

  typedef struct packed {
    logic [31:0] inst0;
    logic [31:0] inst1;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_add;
    logic [31:0] badv;
    logic [31:0] cookie;
    logic [6:0]  exception;
    logic [1:0]  excp_flag;
    logic [1:0]  priv_flag;
  } fb_entry_t;

  // Packet presented downstream while the buffer holds nothing.
  function automatic fb_entry_t empty_entry();
    fb_entry_t e;
    e.inst0     = INST_NOP;
    e.inst1     = INST_NOP;
    e.pc        = PC_RESET;
    e.pc_next   = PC_RESET + 32'd8;
    e.pc_add    = PC_RESET + 32'd4;
    e.badv      = PC_RESET;
    e.cookie    = EMPTY_COOKIE;
    e.exception = '0;
    e.excp_flag = '0;
    e.priv_flag = '0;
    return e;
  endfunction

endpackage

// File: rtl/fetch_buffer_ram.sv
// Entry storage for the fetch buffer: synchronous write, combinational read.
// Contents are not reset; validity is tracked by the buffer's pointers.
module fetch_buffer_ram
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  fb_entry_t     wdata,
  input  logic [PW-1:0] raddr,
  output fb_entry_t     rdata
);

  fb_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_buffer.sv
// Circular fetch-packet buffer between IF and the FIFO/ID register.
// No bypass: a packet written this cycle is visible at the head next cycle.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fifo_flush,
  input  logic        if_readygo,
  output logic        buf_allowin,
  input  logic [31:0] if_inst0,
  input  logic [31:0] if_inst1,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_pc_next,
  input  logic [31:0] if_pcAdd,
  input  logic [31:0] if_badv,
  input  logic [31:0] if_cookie_out,
  input  logic [6:0]  if_exception,
  input  logic [1:0]  if_excp_flag,
  input  logic [1:0]  if_priv_flag,
  output logic        fifo_readygo,
  input  logic        fifo_allowin,
  output logic [31:0] fifo_inst0,
  output logic [31:0] fifo_inst1,
  output logic [31:0] fifo_pc,
  output logic [31:0] fifo_pc_next,
  output logic [31:0] fifo_pcAdd,
  output logic [31:0] fifo_badv,
  output logic [31:0] fifo_cookie_out,
  output logic [6:0]  fifo_exception,
  output logic [1:0]  fifo_excp_flag,
  output logic [1:0]  fifo_priv_flag,
  output logic        fetch_buf_empty,
  output logic        fetch_buf_full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop;
  fb_entry_t     wr_entry;
  fb_entry_t     rd_entry;
  fb_entry_t     head_entry;

  assign fetch_buf_empty = (count_q == '0);
  assign fetch_buf_full  = (count_q == CW'(DEPTH));
  assign buf_allowin     = !fetch_buf_full;
  assign fifo_readygo    = !fetch_buf_empty;
  assign push            = if_readygo & buf_allowin;
  assign pop             = fifo_readygo & fifo_allowin;

  // Flush wins over push and pop; pointer arithmetic wraps at the power-of-two depth.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (fifo_flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        tail_q <= tail_q + PW'(1);
      end
      if (pop) begin
        head_q <= head_q + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  always_comb begin
    wr_entry           = '0;
    wr_entry.inst0     = if_inst0;
    wr_entry.inst1     = if_inst1;
    wr_entry.pc        = if_pc;
    wr_entry.pc_next   = if_pc_next;
    wr_entry.pc_add    = if_pcAdd;
    wr_entry.badv      = if_badv;
    wr_entry.cookie    = if_cookie_out;
    wr_entry.exception = if_exception;
    wr_entry.excp_flag = if_excp_flag;
    wr_entry.priv_flag = if_priv_flag;
  end

  fetch_buffer_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push & ~fifo_flush),
    .waddr (tail_q),
    .wdata (wr_entry),
    .raddr (head_q),
    .rdata (rd_entry)
  );

  always_comb begin
    head_entry = fetch_buf_empty ? empty_entry() : rd_entry;
  end

  assign fifo_inst0      = head_entry.inst0;
  assign fifo_inst1      = head_entry.inst1;
  assign fifo_pc         = head_entry.pc;
  assign fifo_pc_next    = head_entry.pc_next;
  assign fifo_pcAdd      = head_entry.pc_add;
  assign fifo_badv       = head_entry.badv;
  assign fifo_cookie_out = head_entry.cookie;
  assign fifo_exception  = head_entry.exception;
  assign fifo_excp_flag  = head_entry.excp_flag;
  assign fifo_priv_flag  = head_entry.priv_flag;

endmodule
